// File: rtl/reset_domain_sequencer.sv
// Staged per-channel reset / clock-enable / init generator with per-channel re-reset in RUN.
// Optional status outputs (seq_state, rereset_cnt) are built when RESET_SEQ_STATUS_EN is defined.
module reset_domain_sequencer #(
    parameter int CHANNELS              = 4,
    parameter int RESETWAITCYCLES       = 625000,
    parameter int RESETCYCLELENGTH      = 16,
    parameter int OPERATIONALWAITCYCLES = 25000,
    parameter int INITIALIZEWAITCYCLES  = 1024
) (
    input  logic                sys_clk,
    input  logic                sync_rst_n,
    input  logic                clk_en,
    input  logic [CHANNELS-1:0] rst_trigger,
    output logic [CHANNELS-1:0] rst_out,
    output logic [CHANNELS-1:0] clk_en_out,
    output logic [CHANNELS-1:0] init_out,
    output logic [CHANNELS-1:0] chan_ready,
    output logic                seq_done
`ifdef RESET_SEQ_STATUS_EN
    ,
    output logic [2:0]          seq_state,
    output logic [7:0]          rereset_cnt
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int RELEASE_LEN = CHANNELS * RESETCYCLELENGTH;
    localparam int MAXP = max2(max2(RESETWAITCYCLES, RELEASE_LEN),
                               max2(OPERATIONALWAITCYCLES, INITIALIZEWAITCYCLES));
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] PU_LAST   = CW'(RESETWAITCYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'(RELEASE_LEN - 1);
    localparam logic [CW-1:0] OPW_LAST  = CW'(OPERATIONALWAITCYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INITIALIZEWAITCYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESETCYCLELENGTH - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [2:0] {
        G_POWERUP = 3'd0,
        G_RELEASE = 3'd1,
        G_OPWAIT  = 3'd2,
        G_INIT    = 3'd3,
        G_RUN     = 3'd4
    } gstate_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_HOLD = 2'd1,
        C_INIT = 2'd2
    } cstate_t;

    gstate_t             gstate_q;
    logic [CW-1:0]       gcnt_q;
    logic [CHANNELS-1:0] rst_q;
    logic [CHANNELS-1:0] cen_q;
    logic [CHANNELS-1:0] init_q;
    logic [CHANNELS-1:0] rdy_q;
    logic                done_q;
    cstate_t             cstate_q [CHANNELS];
    logic [CW-1:0]       ccnt_q   [CHANNELS];

    // Every state change is qualified by clk_en, so all outputs freeze while it is low.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            gstate_q <= G_POWERUP;
            gcnt_q   <= '0;
            rst_q    <= '1;
            cen_q    <= '0;
            init_q   <= '0;
            rdy_q    <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cstate_q[i] <= C_IDLE;
                ccnt_q[i]   <= '0;
            end
        end else if (clk_en) begin
            case (gstate_q)
                G_POWERUP: begin
                    if (gcnt_q == PU_LAST) begin
                        gstate_q <= G_RELEASE;
                        gcnt_q   <= '0;
                    end else begin
                        gcnt_q <= gcnt_q + ONE;
                    end
                end
                G_RELEASE: begin
                    // Channel i leaves reset once (i+1) release slots have elapsed.
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (gcnt_q == CW'((i + 1) * RESETCYCLELENGTH - 1)) begin
                            rst_q[i] <= 1'b0;
                        end
                    end
                    if (gcnt_q == REL_LAST) begin
                        gstate_q <= G_OPWAIT;
                        gcnt_q   <= '0;
                    end else begin
                        gcnt_q <= gcnt_q + ONE;
                    end
                end
                G_OPWAIT: begin
                    if (gcnt_q == OPW_LAST) begin
                        cen_q    <= '1;
                        init_q   <= '1;
                        gstate_q <= G_INIT;
                        gcnt_q   <= '0;
                    end else begin
                        gcnt_q <= gcnt_q + ONE;
                    end
                end
                G_INIT: begin
                    if (gcnt_q == INIT_LAST) begin
                        init_q   <= '0;
                        rdy_q    <= '1;
                        done_q   <= 1'b1;
                        gstate_q <= G_RUN;
                        gcnt_q   <= '0;
                    end else begin
                        gcnt_q <= gcnt_q + ONE;
                    end
                end
                G_RUN: begin
                    // Independent re-reset engines; a trigger in HOLD or INIT restarts HOLD.
                    for (int i = 0; i < CHANNELS; i++) begin
                        case (cstate_q[i])
                            C_IDLE: begin
                                if (rst_trigger[i]) begin
                                    cstate_q[i] <= C_HOLD;
                                    ccnt_q[i]   <= '0;
                                    rst_q[i]    <= 1'b1;
                                    cen_q[i]    <= 1'b0;
                                    rdy_q[i]    <= 1'b0;
                                end
                            end
                            C_HOLD: begin
                                if (rst_trigger[i]) begin
                                    ccnt_q[i] <= '0;
                                end else if (ccnt_q[i] == HOLD_LAST) begin
                                    cstate_q[i] <= C_INIT;
                                    ccnt_q[i]   <= '0;
                                    rst_q[i]    <= 1'b0;
                                    cen_q[i]    <= 1'b1;
                                    init_q[i]   <= 1'b1;
                                end else begin
                                    ccnt_q[i] <= ccnt_q[i] + ONE;
                                end
                            end
                            C_INIT: begin
                                if (rst_trigger[i]) begin
                                    cstate_q[i] <= C_HOLD;
                                    ccnt_q[i]   <= '0;
                                    rst_q[i]    <= 1'b1;
                                    cen_q[i]    <= 1'b0;
                                    init_q[i]   <= 1'b0;
                                end else if (ccnt_q[i] == INIT_LAST) begin
                                    cstate_q[i] <= C_IDLE;
                                    ccnt_q[i]   <= '0;
                                    init_q[i]   <= 1'b0;
                                    rdy_q[i]    <= 1'b1;
                                end else begin
                                    ccnt_q[i] <= ccnt_q[i] + ONE;
                                end
                            end
                            default: begin
                                cstate_q[i] <= C_IDLE;
                                ccnt_q[i]   <= '0;
                            end
                        endcase
                    end
                end
                default: begin
                    gstate_q <= G_POWERUP;
                    gcnt_q   <= '0;
                end
            endcase
        end
    end

    assign rst_out    = rst_q;
    assign clk_en_out = cen_q;
    assign init_out   = init_q;
    assign chan_ready = rdy_q;
    assign seq_done   = done_q;

`ifdef RESET_SEQ_STATUS_EN
    logic [CHANNELS-1:0] accept_d;
    logic [8:0]          cnt_sum_d;
    logic [7:0]          rereset_cnt_d;
    logic [7:0]          rereset_cnt_q;

    // Only IDLE->HOLD transitions count as accepted re-resets.
    always_comb begin
        accept_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept_d[i] = clk_en && (gstate_q == G_RUN) && (cstate_q[i] == C_IDLE) && rst_trigger[i];
        end
        cnt_sum_d     = {1'b0, rereset_cnt_q} + 9'($countones(accept_d));
        rereset_cnt_d = cnt_sum_d[8] ? 8'hFF : cnt_sum_d[7:0];
    end

    always_ff @(posedge sys_clk) begin
        if (!sync_rst_n) begin
            rereset_cnt_q <= '0;
        end else begin
            rereset_cnt_q <= rereset_cnt_d;
        end
    end

    assign seq_state   = gstate_q;
    assign rereset_cnt = rereset_cnt_q;
`endif

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// Directed bench for reset_domain_sequencer: bring-up timeline, clk_en stall, re-reset,
// re-trigger, held trigger, mid-sequence reset and trigger suppression before RUN.
module tb_reset_domain_sequencer;
    localparam int CH = 3;

    logic          sys_clk = 1'b0;
    logic          sync_rst_n;
    logic          clk_en;
    logic [CH-1:0] rst_trigger;
    logic [CH-1:0] rst_out;
    logic [CH-1:0] clk_en_out;
    logic [CH-1:0] init_out;
    logic [CH-1:0] chan_ready;
    logic          seq_done;
`ifdef RESET_SEQ_STATUS_EN
    logic [2:0]    seq_state;
    logic [7:0]    rereset_cnt;
`endif
    logic [12:0]   obs;

    int n_pass  = 0;
    int n_total = 0;

    always #5 sys_clk = ~sys_clk;

    reset_domain_sequencer #(
        .CHANNELS              (CH),
        .RESETWAITCYCLES       (8),
        .RESETCYCLELENGTH      (4),
        .OPERATIONALWAITCYCLES (6),
        .INITIALIZEWAITCYCLES  (5)
    ) dut (
        .sys_clk     (sys_clk),
        .sync_rst_n  (sync_rst_n),
        .clk_en      (clk_en),
        .rst_trigger (rst_trigger),
        .rst_out     (rst_out),
        .clk_en_out  (clk_en_out),
        .init_out    (init_out),
        .chan_ready  (chan_ready),
        .seq_done    (seq_done)
`ifdef RESET_SEQ_STATUS_EN
        ,
        .seq_state   (seq_state),
        .rereset_cnt (rereset_cnt)
`endif
    );

    // Layout: [12:10] rst_out, [9:7] clk_en_out, [6:4] init_out, [3:1] chan_ready, [0] seq_done
    assign obs = {rst_out, clk_en_out, init_out, chan_ready, seq_done};

    function automatic logic [12:0] bring_exp(input int c);
        logic [2:0] r;
        logic [2:0] ce;
        logic [2:0] in;
        logic [2:0] rd;
        logic       d;
        r[0] = (c < 12);
        r[1] = (c < 16);
        r[2] = (c < 20);
        ce   = (c >= 26) ? 3'b111 : 3'b000;
        in   = (c >= 26 && c <= 30) ? 3'b111 : 3'b000;
        rd   = (c >= 31) ? 3'b111 : 3'b000;
        d    = (c >= 31);
        return {r, ce, in, rd, d};
    endfunction

    function automatic logic [12:0] set_ch(input logic [12:0] v, input int ch,
                                           input logic r, input logic ce,
                                           input logic in, input logic rd);
        logic [12:0] o;
        o          = v;
        o[10 + ch] = r;
        o[7 + ch]  = ce;
        o[4 + ch]  = in;
        o[1 + ch]  = rd;
        return o;
    endfunction

    // Single re-reset pulse at k=0: HOLD on 1..4, INIT on 5..9, ready again from 10.
    function automatic logic [12:0] rr1(input logic [12:0] v, input int ch, input int k);
        logic hold;
        logic ini;
        hold = (k >= 1 && k <= 4);
        ini  = (k >= 5 && k <= 9);
        return set_ch(v, ch, hold, !hold, ini, !(hold || ini));
    endfunction

    task automatic check(input string tag, input int cyc, input logic [12:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, exp);
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        sync_rst_n  = 1'b0;
        rst_trigger = '0;
        clk_en      = 1'b1;
        tick();
        check("reset_enter", 0, bring_exp(0));
        tick();
        check("reset_hold", 0, bring_exp(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] allup;
        logic [12:0] e;
        logic        hold;
        logic        ini;
        allup       = bring_exp(40);
        sync_rst_n  = 1'b0;
        clk_en      = 1'b1;
        rst_trigger = '0;
        tick();
        tick();
        check("reset_init", 0, bring_exp(0));

        // Clean bring-up
        sync_rst_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            check("bringup", c, bring_exp(c));
            tick();
        end

        // Single pulse on channel 1
        for (int k = 0; k < 12; k++) begin
            rst_trigger = (k == 0) ? 3'b010 : 3'b000;
            check("rereset1", k, rr1(allup, 1, k));
            tick();
        end

        // Channel 2 re-triggered during its INIT phase
        for (int k = 0; k < 18; k++) begin
            rst_trigger = (k == 0 || k == 6) ? 3'b100 : 3'b000;
            hold = (k >= 1 && k <= 4) || (k >= 7 && k <= 10);
            ini  = (k >= 5 && k <= 6) || (k >= 11 && k <= 15);
            check("retrig2", k, set_ch(allup, 2, hold, !hold, ini, !(hold || ini)));
            tick();
        end

        // Channel 0 trigger held for 8 cycles, channel 1 pulsed in parallel
        for (int k = 0; k < 19; k++) begin
            rst_trigger = ((k < 8) ? 3'b001 : 3'b000) | ((k == 0) ? 3'b010 : 3'b000);
            hold = (k >= 1 && k <= 11);
            ini  = (k >= 12 && k <= 16);
            e    = set_ch(allup, 0, hold, !hold, ini, !(hold || ini));
            check("held_par", k, rr1(e, 1, k));
            tick();
        end

        // Reset in RUN, then a one-cycle reset at cycle 15 of bring-up
        do_reset();
        sync_rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c == 15) sync_rst_n = 1'b0;
            check("pre_abort", c, bring_exp(c));
            tick();
        end
        sync_rst_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            check("restart", c, bring_exp(c));
            tick();
        end

        // Triggers before RUN are ignored
        do_reset();
        sync_rst_n = 1'b1;
        for (int c = 0; c < 34; c++) begin
            rst_trigger = (c <= 25) ? 3'b111 : 3'b000;
            check("trig_ignored", c, bring_exp(c));
            tick();
        end

        // clk_en low on cycles 3..12 shifts the timeline by 10
        do_reset();
        sync_rst_n = 1'b1;
        for (int c = 0; c < 45; c++) begin
            clk_en = !(c >= 3 && c <= 12);
            if (c <= 3)       e = bring_exp(c);
            else if (c <= 13) e = bring_exp(3);
            else              e = bring_exp(c - 10);
            check("clk_en_stall", c, e);
            tick();
        end
        clk_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
